// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared sizing defaults and constants for the register file, write-back latch and scoreboard.
package regfile_wb_scoreboard_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with set-over-clear priority and the decode stall decision.
module regfile_scoreboard
  import regfile_wb_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_src1,
  input  logic [ADDR_W-1:0] issue_src2,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  output logic              stall
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [NREG-1:0] busy;
  logic            hz_src1;
  logic            hz_src2;
  logic            hz_dest;
  logic            accept;

  // A register whose producer sits in the write-back latch is covered by the bypass.
  function automatic logic hazard(input logic [ADDR_W-1:0] r,
                                  input logic [NREG-1:0]   bv,
                                  input logic              v,
                                  input logic [ADDR_W-1:0] wr);
    return (r != ADDR_W'(REG_ZERO)) && bv[r] && !(v && (wr == r));
  endfunction

  always_comb begin
    hz_src1 = hazard(issue_src1, busy, wb_valid, wb_reg);
    hz_src2 = hazard(issue_src2, busy, wb_valid, wb_reg);
    hz_dest = hazard(issue_dest, busy, wb_valid, wb_reg);
    stall   = rst_n && issue_valid && (hz_src1 || hz_src2 || hz_dest);
    accept  = issue_valid && !stall;
  end

  // The set is issued last so a new producer wins over a same-edge completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wb_valid) begin
        busy[wb_reg] <= 1'b0;
      end
      if (accept && (issue_dest != ADDR_W'(REG_ZERO))) begin
        busy[issue_dest] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Architectural register file fed by a one-cycle write-back latch that doubles as the
// decode bypass source; the busy scoreboard decides when decode must stall.
module regfile_wb_scoreboard
  import regfile_wb_scoreboard_pkg::*;
#(
  parameter              NAME   = "RF",
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] RegisterData1,
  output logic [DATA_W-1:0] RegisterData2,
  input  logic              WBValid,
  input  logic [ADDR_W-1:0] WBRegister,
  input  logic [DATA_W-1:0] WBData,
  output logic [ADDR_W-1:0] WriteRegister1stPri1,
  output logic [DATA_W-1:0] WriteData1stPri1,
  output logic              Valid1stPri1,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueSrc1,
  input  logic [ADDR_W-1:0] IssueSrc2,
  input  logic [ADDR_W-1:0] IssueDest,
  output logic              Stall
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [DATA_W-1:0] mem [NREG];

  // NAME is a debug tag only; this empty scope just carries it into the hierarchy.
  if ($bits(NAME) == 0) begin : g_untagged
  end

  // Write-back latch and array commit; register 0 is never targeted because the
  // latch valid is already qualified against it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem                  <= '{default: '0};
      Valid1stPri1         <= 1'b0;
      WriteRegister1stPri1 <= '0;
      WriteData1stPri1     <= '0;
    end else begin
      Valid1stPri1         <= WBValid && (WBRegister != ADDR_W'(REG_ZERO));
      WriteRegister1stPri1 <= WBRegister;
      WriteData1stPri1     <= WBData;
      if (Valid1stPri1) begin
        mem[WriteRegister1stPri1] <= WriteData1stPri1;
      end
    end
  end

  assign RegisterData1 = mem[ReadRegister1];
  assign RegisterData2 = mem[ReadRegister2];

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (CLK),
    .rst_n       (RESET),
    .issue_valid (IssueValid),
    .issue_src1  (IssueSrc1),
    .issue_src2  (IssueSrc2),
    .issue_dest  (IssueDest),
    .wb_valid    (Valid1stPri1),
    .wb_reg      (WriteRegister1stPri1),
    .stall       (Stall)
  );

endmodule
